// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - parametrised serial pattern detector with reloadable pattern and saturating match counter
// Optional don't-care mask on the compare: define SEQ_DET_MASK_EN.
module seq_detector_param #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter int               CNT_W   = 8
) (
    input  logic             CLK,
    input  logic             RET,
    input  logic             DATA_VALID,
    input  logic             DATA_IN,
    input  logic             OVERLAP,
    input  logic             PAT_LOAD,
    input  logic [PAT_W-1:0] PAT_IN,
`ifdef SEQ_DET_MASK_EN
    input  logic [PAT_W-1:0] PAT_MASK_IN,
`endif
    input  logic             CNT_CLR,
    output logic             MATCH,
    output logic [CNT_W-1:0] MATCH_CNT,
    output logic             CNT_SAT
);

    localparam int             FW   = $clog2(PAT_W + 1);
    localparam logic [FW-1:0]  FULL = FW'(PAT_W);

    typedef enum logic {S_FILL, S_ARMED} state_t;

    state_t             r_state;
    logic [PAT_W-1:0]   r_pat;
    logic [PAT_W-1:0]   r_hist;
    logic [FW-1:0]      r_fill;
    logic               r_match;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_sat;

    logic               w_accept;
    logic               w_fill_bad;
    logic [PAT_W-1:0]   w_hist_next;
    logic [FW-1:0]      w_fill_next;
    logic [FW-1:0]      w_fill_store;
    logic               w_cmp;
    logic               w_hit;
    logic [CNT_W-1:0]   w_cnt_next;

    // A reload in the same cycle wins over the data bit, so that bit is never accepted.
    assign w_accept    = DATA_VALID && !PAT_LOAD;
    assign w_fill_bad  = r_fill > FULL;
    assign w_hist_next = {r_hist[PAT_W-2:0], DATA_IN};
    assign w_fill_next = w_fill_bad           ? '0   :
                         (r_state == S_ARMED) ? FULL : r_fill + FW'(1);

`ifdef SEQ_DET_MASK_EN
    logic [PAT_W-1:0]   r_mask;
    assign w_cmp = ((w_hist_next ^ r_pat) & r_mask) == '0;
`else
    assign w_cmp = (w_hist_next == r_pat);
`endif

    assign w_hit        = w_accept && (w_fill_next == FULL) && w_cmp;
    assign w_fill_store = (w_hit && !OVERLAP) ? '0 : w_fill_next;

    always_comb begin
        w_cnt_next = r_cnt;
        if (CNT_CLR)
            w_cnt_next = w_hit ? CNT_W'(1) : '0;
        else if (w_hit && !(&r_cnt))
            w_cnt_next = r_cnt + CNT_W'(1);
    end

    always_ff @(posedge CLK) begin
        if (RET) begin
            r_state <= S_FILL;
            r_pat   <= PATTERN;
            r_hist  <= '0;
            r_fill  <= '0;
            r_match <= 1'b0;
            r_cnt   <= '0;
            r_sat   <= 1'b0;
`ifdef SEQ_DET_MASK_EN
            r_mask  <= '1;
`endif
        end else begin
            r_match <= w_hit;
            r_cnt   <= w_cnt_next;
            r_sat   <= &w_cnt_next;
            if (PAT_LOAD) begin
                r_pat   <= PAT_IN;
                r_hist  <= '0;
                r_fill  <= '0;
                r_state <= S_FILL;
`ifdef SEQ_DET_MASK_EN
                r_mask  <= PAT_MASK_IN;
`endif
            end else if (w_accept) begin
                r_hist  <= w_hist_next;
                r_fill  <= w_fill_store;
                r_state <= (w_fill_store == FULL) ? S_ARMED : S_FILL;
            end else if (w_fill_bad) begin
                r_fill  <= '0;
                r_state <= S_FILL;
            end
        end
    end

    assign MATCH     = r_match;
    assign MATCH_CNT = r_cnt;
    assign CNT_SAT   = r_sat;

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - directed vector bench for seq_detector_param
module tb_seq_detector_param;

    logic       CLK = 1'b0;
    logic       RET = 1'b1;
    logic       DATA_VALID = 1'b0;
    logic       DATA_IN = 1'b0;
    logic       OVERLAP = 1'b1;
    logic       PAT_LOAD = 1'b0;
    logic [3:0] PAT_IN = 4'b0000;
    logic [3:0] PAT_MASK_IN = 4'b1111;
    logic       CNT_CLR = 1'b0;

    logic       match_a, sat_a, match_b, sat_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    seq_detector_param #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(8)) u_a (
        .CLK(CLK), .RET(RET), .DATA_VALID(DATA_VALID), .DATA_IN(DATA_IN),
        .OVERLAP(OVERLAP), .PAT_LOAD(PAT_LOAD), .PAT_IN(PAT_IN),
`ifdef SEQ_DET_MASK_EN
        .PAT_MASK_IN(PAT_MASK_IN),
`endif
        .CNT_CLR(CNT_CLR), .MATCH(match_a), .MATCH_CNT(cnt_a), .CNT_SAT(sat_a)
    );

    seq_detector_param #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(2)) u_b (
        .CLK(CLK), .RET(RET), .DATA_VALID(DATA_VALID), .DATA_IN(DATA_IN),
        .OVERLAP(OVERLAP), .PAT_LOAD(PAT_LOAD), .PAT_IN(PAT_IN),
`ifdef SEQ_DET_MASK_EN
        .PAT_MASK_IN(PAT_MASK_IN),
`endif
        .CNT_CLR(CNT_CLR), .MATCH(match_b), .MATCH_CNT(cnt_b), .CNT_SAT(sat_b)
    );

    typedef struct {
        logic       rst, dv, din, ovl, load, clr;
        logic [3:0] pin;
        logic       e_match;
        logic [7:0] e_cnt;
        logic       e_sat;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic rst, logic dv, logic din, logic ovl, logic load,
                                logic [3:0] pin, logic clr, logic em, logic [7:0] ec, logic es);
        vec_t v;
        v.rst = rst; v.dv = dv; v.din = din; v.ovl = ovl; v.load = load;
        v.pin = pin; v.clr = clr; v.e_match = em; v.e_cnt = ec; v.e_sat = es;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d actual=%0h expected=%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic dv, input logic din, input logic ovl,
                         input logic load, input logic [3:0] pin, input logic clr);
        RET = rst; DATA_VALID = dv; DATA_IN = din; OVERLAP = ovl;
        PAT_LOAD = load; PAT_IN = pin; CNT_CLR = clr;
        @(posedge CLK);
        #1;
    endtask

    // bit helpers: accepted bit, idle cycle, reset cycle
    task automatic bitv(input logic din, input logic ovl, input logic em, input logic [7:0] ec);
        vq.push_back(mk(0, 1, din, ovl, 0, 4'h0, 0, em, ec, 0));
    endtask

    task automatic rstv();
        vq.push_back(mk(1, 0, 0, 1, 0, 4'h0, 0, 0, 8'd0, 0));
    endtask

    logic [15:0] sat_stream;
    int          exp_b_cnt;
    logic        exp_b_match;

    initial begin
        // overlapping: 1011011 -> matches after bits 4 and 7
        rstv();
        bitv(1,1,0,0); bitv(0,1,0,0); bitv(1,1,0,0); bitv(1,1,1,1);
        bitv(0,1,0,1); bitv(1,1,0,1); bitv(1,1,1,2);
        // non-overlapping: same stream -> one match
        rstv();
        bitv(1,0,0,0); bitv(0,0,0,0); bitv(1,0,0,0); bitv(1,0,1,1);
        bitv(0,0,0,1); bitv(1,0,0,1); bitv(1,0,0,1);
        // sparse DATA_VALID with garbage on DATA_IN during idle
        rstv();
        bitv(1,1,0,0);
        for (int i = 0; i < 3; i++) vq.push_back(mk(0, 0, 1, 1, 0, 4'h0, 0, 0, 8'd0, 0));
        bitv(0,1,0,0);
        for (int i = 0; i < 3; i++) vq.push_back(mk(0, 0, 1, 1, 0, 4'h0, 0, 0, 8'd0, 0));
        bitv(1,1,0,0);
        for (int i = 0; i < 3; i++) vq.push_back(mk(0, 0, 0, 1, 0, 4'h0, 0, 0, 8'd0, 0));
        bitv(1,1,1,1);
        for (int i = 0; i < 3; i++) vq.push_back(mk(0, 0, 1, 1, 0, 4'h0, 0, 0, 8'd1, 0));
        // pattern reload mid-stream; the bit offered with PAT_LOAD is discarded
        rstv();
        bitv(1,1,0,0); bitv(0,1,0,0); bitv(1,1,0,0);
        vq.push_back(mk(0, 1, 1, 1, 1, 4'b0110, 0, 0, 8'd0, 0));
        bitv(0,1,0,0); bitv(1,1,0,0); bitv(1,1,0,0); bitv(0,1,1,1);
        vq.push_back(mk(0, 0, 0, 1, 1, 4'b1011, 0, 0, 8'd1, 0));
        // CNT_CLR alone
        vq.push_back(mk(0, 0, 0, 1, 0, 4'h0, 1, 0, 8'd0, 0));
        // reset mid-stream discards partial history
        rstv();
        bitv(1,1,0,0); bitv(0,1,0,0); bitv(1,1,0,0);
        rstv();
        bitv(1,1,0,0); bitv(0,1,0,0); bitv(1,1,0,0); bitv(1,1,1,1);

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rst, vq[i].dv, vq[i].din, vq[i].ovl, vq[i].load, vq[i].pin, vq[i].clr);
            chk("match", i, 32'(match_a), 32'(vq[i].e_match));
            chk("cnt",   i, 32'(cnt_a),   32'(vq[i].e_cnt));
            chk("sat",   i, 32'(sat_a),   32'(vq[i].e_sat));
        end

        // CNT_W=2 saturation: 5 overlapping matches at bits 4,7,10,13,16
        drive(1, 0, 0, 1, 0, 4'h0, 0);
        chk("b_reset_cnt", 0, 32'(cnt_b), 32'd0);
        chk("b_reset_sat", 0, 32'(sat_b), 32'd0);
        sat_stream = 16'b1011011011011011;
        exp_b_cnt  = 0;
        for (int i = 0; i < 16; i++) begin
            drive(0, 1, sat_stream[15-i], 1, 0, 4'h0, 0);
            exp_b_match = (i == 3) || (i == 6) || (i == 9) || (i == 12) || (i == 15);
            if (exp_b_match && exp_b_cnt < 3) exp_b_cnt++;
            chk("b_match", i, 32'(match_b), 32'(exp_b_match));
            chk("b_cnt",   i, 32'(cnt_b),   32'(exp_b_cnt));
            chk("b_sat",   i, 32'(sat_b),   32'(exp_b_cnt == 3));
        end
        chk("b_cnt_final", 16, 32'(cnt_b), 32'd3);
        // CNT_CLR coinciding with the sixth match -> count restarts at 1
        drive(0, 1, 0, 1, 0, 4'h0, 0);
        drive(0, 1, 1, 1, 0, 4'h0, 0);
        drive(0, 1, 1, 1, 0, 4'h0, 1);
        chk("b_clr_match", 19, 32'(match_b), 32'd1);
        chk("b_clr_cnt",   19, 32'(cnt_b),   32'd1);
        chk("b_clr_sat",   19, 32'(sat_b),   32'd0);
        // back-to-back: pattern 1111 overlapping gives consecutive pulses
        drive(1, 0, 0, 1, 0, 4'h0, 0);
        drive(0, 0, 0, 1, 1, 4'b1111, 0);
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 1, 1, 0, 4'h0, 0);
            chk("b2b_match", i, 32'(match_a), 32'(i >= 3));
        end
        chk("b2b_cnt", 6, 32'(cnt_a), 32'd3);

`ifdef SEQ_DET_MASK_EN
        drive(1, 0, 0, 1, 0, 4'h0, 0);
        PAT_MASK_IN = 4'b1001;
        drive(0, 0, 0, 1, 1, 4'b1001, 0);
        drive(0, 1, 1, 1, 0, 4'h0, 0);
        drive(0, 1, 1, 1, 0, 4'h0, 0);
        drive(0, 1, 0, 1, 0, 4'h0, 0);
        drive(0, 1, 1, 1, 0, 4'h0, 0);
        chk("mask_match", 0, 32'(match_a), 32'd1);
        drive(0, 1, 0, 1, 0, 4'h0, 0);
        chk("mask_nomatch", 1, 32'(match_a), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised serial bit-pattern detector; successor to the fixed 4-bit Moore sequence detector FSM.
- Adds the following over the fixed detector:
  - width-generic pattern
  - runtime pattern reload
  - input qualifier (DATA_VALID)
  - overlapping and non-overlapping match modes
  - saturating match counter
- Sits between a serial bit source (UART/line decoder) and control logic that consumes MATCH pulses or counts.

Parameters:
- PAT_W, 4, pattern length in bits (legal range 2..32).
- PATTERN, 4'b1011, reset/default pattern. MSB is the first bit received.
- CNT_W, 8, width of MATCH_CNT.

Ports:
- CLK  in  1  clock. All logic is on the rising edge.
- RET  in  1  reset, synchronous, active-high.
- DATA_VALID  in  1  qualifies DATA_IN. A bit is accepted only on edges where this is 1.
- DATA_IN  in  1  serial data bit.
- OVERLAP  in  1  1 = overlapping match mode, 0 = non-overlapping. Sampled per accepted bit.
- PAT_LOAD  in  1  1 = load PAT_IN as the new pattern.
- PAT_IN  in  PAT_W  new pattern value.
- CNT_CLR  in  1  synchronous clear of MATCH_CNT.
- MATCH  out  1  registered one-cycle pulse per detected match.
- MATCH_CNT  out  CNT_W  matches counted since reset or clear; saturating.
- CNT_SAT  out  1  1 while MATCH_CNT is all-ones.

Behaviour:
- Reset (RET=1 at an edge) sets:
  - pat_r = PATTERN
  - hist = 0
  - fill = 0
  - MATCH = 0
  - MATCH_CNT = 0
  - CNT_SAT = 0
- RET has priority over all other inputs.
- State registers:
  - hist[PAT_W-1:0]: shift register. The new bit enters at bit 0; older bits move toward the MSB.
  - fill: counts 0..PAT_W and saturates at PAT_W.
  - FSM states: FILL (fill<PAT_W) and ARMED (fill==PAT_W).
- On each accepted bit: hist_next = {hist[PAT_W-2:0], DATA_IN}; fill increments, saturating at PAT_W.
- Match condition: fill_next==PAT_W and hist_next==pat_r (mask applied if compiled in).
- On a match:
  - MATCH is 1 in the cycle after the accepting edge, for exactly one cycle.
  - Back-to-back matches give MATCH high on consecutive cycles.
- Latency: final pattern bit accepted at edge k -> MATCH high between edge k and edge k+1.
- OVERLAP=1: history is kept after a match. With PATTERN 1011, stream 1011011 gives 2 matches.
- OVERLAP=0: fill is forced to 0 on the match edge. The same stream gives 1 match.
- DATA_VALID=0: hist and fill hold; MATCH=0 next cycle.
- PAT_LOAD=1:
  - pat_r <= PAT_IN; hist and fill clear to 0; MATCH=0 next cycle.
  - Any DATA_IN accepted in the same cycle is discarded.
  - MATCH_CNT is unaffected.
- Match counter:
  - Increments by 1 on each match edge.
  - Holds at 2^CNT_W-1 (no wrap); CNT_SAT is registered alongside it.
- CNT_CLR and a match on the same edge -> MATCH_CNT=1.
- CNT_CLR alone -> MATCH_CNT=0 and CNT_SAT=0.
- Reset mid-stream discards partial history. Matching resumes only after PAT_W new accepted bits.
- Unreachable fill values (>PAT_W) recover to 0 on the next edge.

Optional Feature:
- Macro: SEQ_DET_MASK_EN.
- Defined:
  - Adds input port PAT_MASK_IN [PAT_W-1:0] and register mask_r.
  - mask_r loads from PAT_MASK_IN on PAT_LOAD; reset value is all-ones.
  - Compare becomes ((hist_next ^ pat_r) & mask_r)==0. A mask bit of 0 is don't-care.
  - All-zero mask: every accepted bit with fill_next==PAT_W matches.
- Undefined: port and register are absent; compare is exact equality.

Test Plan:
- Reset, defaults, OVERLAP=1, DATA_VALID=1, stream 1,0,1,1,0,1,1 -> MATCH pulses after bits 4 and 7; MATCH_CNT=2.
- Same stream with OVERLAP=0 -> MATCH pulses after bit 4 only; MATCH_CNT=1.
- Stream 1,0,1,1 with DATA_VALID low for 3 cycles between each bit -> exactly one MATCH, 1 cycle after the 4th valid bit; no pulses in idle cycles.
- PAT_LOAD with PAT_IN=4'b0110 mid-stream (after bits 1,0,1), then stream 0,1,1,0 -> no match from the old partial history; one MATCH after the 4th new bit.
- CNT_W=2, 5 overlapping matches -> MATCH_CNT sequence 1,2,3,3,3; CNT_SAT high from the 3rd match.
  - Then CNT_CLR together with a match -> MATCH_CNT=1, CNT_SAT=0.
- RET asserted after bits 1,0,1, then bit 1 -> no MATCH. With SEQ_DET_MASK_EN, mask 4'b1001 and pattern 1xx1, stream 1,1,0,1 -> MATCH.
